outstream_sink: RTL and testbench

Synthesizable AXI-Stream-style sink for the HLS examples: the receiving end of the stencil streams produced by the stream source and by accelerator outputs. It accepts one stencil window per beat over a 4-D image, drives `tready` with optional pseudo-random backpressure, and tracks frame position. It also checks `tlast` placement and accumulates a checksum plus a beat count, so a bench or on-chip monitor can validate a full frame without file I/O.

---
 rtl/outstream_pkg.sv | 24 ++
 rtl/stall_lfsr.sv | 27 ++
 rtl/outstream_sink.sv | 176 +++++++++++++++++
 tb/tb_outstream_sink.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/outstream_pkg.sv
// Shared types and constants for the stencil stream sink and its stall generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package outstream_pkg;

  // Frame-level control states of the sink.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting right.
  // In the right-shift form the taps land on bits 0, 2, 3 and 5.
  localparam int                LFSR_W            = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'h002D;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // One LFSR step: XOR of the tapped bits enters at the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {^(cur & LFSR_TAPS), cur[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/stall_lfsr.sv
// Free-running pseudo-random bit source used to gate stream handshakes.
// Latency: state advances one step per enabled cycle.
// Backpressure: none; holds its state while enable is low.
module stall_lfsr
  import outstream_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  // An all-zero seed would lock the register up, so it is swapped for the default.
  logic [LFSR_W-1:0] seed_eff;
  assign seed_eff = (seed == '0) ? LFSR_DEFAULT_SEED : seed;

  // Load the seed on reset, step while enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= seed_eff;
    end else if (enable) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/outstream_sink.sv
// Stencil stream sink: accepts one window per beat, tracks 4-D position, sums data, checks tlast.
// Latency: counters/flags visible one cycle after the accepting edge; tready is registered.
// Backpressure: tready low outside RUN; in RUN it is LFSR-gated or held high per RANDOM_STALL.
module outstream_sink
  import outstream_pkg::*;
#(
  parameter int          IMG_EXTENT_0 = 256,
  parameter int          IMG_EXTENT_1 = 256,
  parameter int          IMG_EXTENT_2 = 1,
  parameter int          IMG_EXTENT_3 = 1,
  parameter int          ST_EXTENT_0  = 1,
  parameter int          ST_EXTENT_1  = 1,
  parameter int          ST_EXTENT_2  = 1,
  parameter int          ST_EXTENT_3  = 1,
  parameter int          DATA_SIZE    = 8,
  parameter bit          RANDOM_STALL = 1'b1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          CHECKSUM_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_in,
  input  logic [DATA_SIZE-1:0]  tdata [ST_EXTENT_3][ST_EXTENT_2][ST_EXTENT_1][ST_EXTENT_0],
  input  logic                  tvalid,
  input  logic                  tlast,
  output logic                  tready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           beat_count,
  output logic [CHECKSUM_W-1:0] checksum,
  output logic                  err_early_last,
  output logic                  err_missing_last
);

  // Index widths hold every legal position; extents of 1 give 1-bit counters that stay at 0.
  localparam int IW0 = $clog2(IMG_EXTENT_0 + 1);
  localparam int IW1 = $clog2(IMG_EXTENT_1 + 1);
  localparam int IW2 = $clog2(IMG_EXTENT_2 + 1);
  localparam int IW3 = $clog2(IMG_EXTENT_3 + 1);

  localparam logic [IW0-1:0] LAST0 = IW0'(IMG_EXTENT_0 - ST_EXTENT_0);
  localparam logic [IW1-1:0] LAST1 = IW1'(IMG_EXTENT_1 - ST_EXTENT_1);
  localparam logic [IW2-1:0] LAST2 = IW2'(IMG_EXTENT_2 - ST_EXTENT_2);
  localparam logic [IW3-1:0] LAST3 = IW3'(IMG_EXTENT_3 - ST_EXTENT_3);
  localparam logic [IW0-1:0] STEP0 = IW0'(ST_EXTENT_0);
  localparam logic [IW1-1:0] STEP1 = IW1'(ST_EXTENT_1);
  localparam logic [IW2-1:0] STEP2 = IW2'(ST_EXTENT_2);
  localparam logic [IW3-1:0] STEP3 = IW3'(ST_EXTENT_3);

  // Per-beat sum is wide enough to never overflow before folding into the checksum.
  localparam int NELEM = ST_EXTENT_0 * ST_EXTENT_1 * ST_EXTENT_2 * ST_EXTENT_3;
  localparam int SUM_W = DATA_SIZE + $clog2(NELEM + 1);

  state_t            state;
  logic [IW0-1:0]    idx_0;
  logic [IW1-1:0]    idx_1;
  logic [IW2-1:0]    idx_2;
  logic [IW3-1:0]    idx_3;
  logic [LFSR_W-1:0] lfsr_state;
  logic              wrap_0, wrap_1, wrap_2, wrap_3;
  logic              final_beat;
  logic              accept;
  logic              run_ready;
  logic [SUM_W-1:0]  beat_sum;
  logic              unused_lfsr_hi;

  stall_lfsr u_stall (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (state == ST_RUN),
    .seed    (LFSR_SEED),
    .state   (lfsr_state)
  );

  // Only bit 0 gates tready; the rest of the LFSR state is internal to the generator.
  assign unused_lfsr_hi = ^lfsr_state[LFSR_W-1:1];

  assign wrap_0     = (idx_0 == LAST0);
  assign wrap_1     = (idx_1 == LAST1);
  assign wrap_2     = (idx_2 == LAST2);
  assign wrap_3     = (idx_3 == LAST3);
  assign final_beat = wrap_0 & wrap_1 & wrap_2 & wrap_3;
  assign accept     = (state == ST_RUN) && tvalid && tready;
  assign run_ready  = RANDOM_STALL ? lfsr_state[0] : 1'b1;

  // Sum every element of the stencil window, zero-extended.
  always_comb begin
    beat_sum = '0;
    for (int i3 = 0; i3 < ST_EXTENT_3; i3++) begin
      for (int i2 = 0; i2 < ST_EXTENT_2; i2++) begin
        for (int i1 = 0; i1 < ST_EXTENT_1; i1++) begin
          for (int i0 = 0; i0 < ST_EXTENT_0; i0++) begin
            beat_sum = beat_sum + SUM_W'(tdata[i3][i2][i1][i0]);
          end
        end
      end
    end
  end

  // Frame FSM with registered handshake, status, counters and tlast checks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      tready           <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      beat_count       <= '0;
      checksum         <= '0;
      err_early_last   <= 1'b0;
      err_missing_last <= 1'b0;
      idx_0            <= '0;
      idx_1            <= '0;
      idx_2            <= '0;
      idx_3            <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_in) begin
            // New frame: everything frame-scoped clears on the same edge.
            state            <= ST_RUN;
            busy             <= 1'b1;
            done             <= 1'b0;
            tready           <= run_ready;
            beat_count       <= '0;
            checksum         <= '0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
            idx_0            <= '0;
            idx_1            <= '0;
            idx_2            <= '0;
            idx_3            <= '0;
          end else begin
            tready <= 1'b0;
          end
        end
        ST_RUN: begin
          tready <= run_ready;
          if (accept) begin
            beat_count <= beat_count + 32'd1;
            checksum   <= checksum + CHECKSUM_W'(beat_sum);
            idx_0      <= wrap_0 ? '0 : idx_0 + STEP0;
            if (wrap_0) begin
              idx_1 <= wrap_1 ? '0 : idx_1 + STEP1;
            end
            if (wrap_0 && wrap_1) begin
              idx_2 <= wrap_2 ? '0 : idx_2 + STEP2;
            end
            if (wrap_0 && wrap_1 && wrap_2) begin
              idx_3 <= wrap_3 ? '0 : idx_3 + STEP3;
            end
            if (tlast && !final_beat) begin
              err_early_last <= 1'b1;
            end
            if (final_beat) begin
              // The frame ends on position alone; a missing tlast is only flagged.
              if (!tlast) begin
                err_missing_last <= 1'b1;
              end
              state  <= ST_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              tready <= 1'b0;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          tready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_outstream_sink.sv
// Scoreboard bench for outstream_sink: three configurations driven one at a time.
module tb_outstream_sink;

  localparam int LIMIT = 4000;

  // Instance 0: 4x2 image, 1x1 stencil, no stalls.
  // Instance 1: 4x2 image, 2-wide stencil, random stalls.
  // Instance 2: 256x1 image, 1x1 stencil, random stalls.
  localparam int TOTAL_0 = (4 / 1) * (2 / 1);
  localparam int TOTAL_1 = (4 / 2) * (2 / 1);
  localparam int TOTAL_2 = (256 / 1) * (1 / 1);

  typedef struct packed {
    logic [1:0]  inst;
    logic [31:0] bc;
    logic [31:0] cs;
    logic        ee;
    logic        em;
    logic        fin;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start_s  [3];
  logic        tvalid_s [3];
  logic        tlast_s  [3];
  logic        tready_s [3];
  logic        busy_s   [3];
  logic        done_s   [3];
  logic [31:0] bc_s     [3];
  logic [31:0] cs_s     [3];
  logic        ee_s     [3];
  logic        em_s     [3];
  logic        acc_seen [3];
  logic [7:0]  td_a [1][1][1][1];
  logic [7:0]  td_b [1][1][1][2];
  logic [7:0]  td_c [1][1][1][1];

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  outstream_sink #(
    .IMG_EXTENT_0(4), .IMG_EXTENT_1(2), .IMG_EXTENT_2(1), .IMG_EXTENT_3(1),
    .ST_EXTENT_0(1), .ST_EXTENT_1(1), .ST_EXTENT_2(1), .ST_EXTENT_3(1),
    .DATA_SIZE(8), .RANDOM_STALL(1'b0), .LFSR_SEED(16'hACE1), .CHECKSUM_W(32)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .start_in(start_s[0]), .tdata(td_a),
    .tvalid(tvalid_s[0]), .tlast(tlast_s[0]), .tready(tready_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .beat_count(bc_s[0]), .checksum(cs_s[0]),
    .err_early_last(ee_s[0]), .err_missing_last(em_s[0])
  );

  outstream_sink #(
    .IMG_EXTENT_0(4), .IMG_EXTENT_1(2), .IMG_EXTENT_2(1), .IMG_EXTENT_3(1),
    .ST_EXTENT_0(2), .ST_EXTENT_1(1), .ST_EXTENT_2(1), .ST_EXTENT_3(1),
    .DATA_SIZE(8), .RANDOM_STALL(1'b1), .LFSR_SEED(16'h1234), .CHECKSUM_W(32)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .start_in(start_s[1]), .tdata(td_b),
    .tvalid(tvalid_s[1]), .tlast(tlast_s[1]), .tready(tready_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .beat_count(bc_s[1]), .checksum(cs_s[1]),
    .err_early_last(ee_s[1]), .err_missing_last(em_s[1])
  );

  outstream_sink #(
    .IMG_EXTENT_0(256), .IMG_EXTENT_1(1), .IMG_EXTENT_2(1), .IMG_EXTENT_3(1),
    .ST_EXTENT_0(1), .ST_EXTENT_1(1), .ST_EXTENT_2(1), .ST_EXTENT_3(1),
    .DATA_SIZE(8), .RANDOM_STALL(1'b1), .LFSR_SEED(16'hACE1), .CHECKSUM_W(32)
  ) u_c (
    .clk(clk), .reset_n(reset_n), .start_in(start_s[2]), .tdata(td_c),
    .tvalid(tvalid_s[2]), .tlast(tlast_s[2]), .tready(tready_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .beat_count(bc_s[2]), .checksum(cs_s[2]),
    .err_early_last(ee_s[2]), .err_missing_last(em_s[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int total_of(input int inst);
    case (inst)
      0:       return TOTAL_0;
      1:       return TOTAL_1;
      default: return TOTAL_2;
    endcase
  endfunction

  task automatic drive_beat(input int inst, input logic v, input logic l,
                            input logic [7:0] d0, input logic [7:0] d1);
    tvalid_s[inst] = v;
    tlast_s[inst]  = l;
    case (inst)
      0: td_a[0][0][0][0] = d0;
      1: begin
        td_b[0][0][0][0] = d0;
        td_b[0][0][0][1] = d1;
      end
      default: td_c[0][0][0][0] = d0;
    endcase
  endtask

  // Data modes: 0 = sequential 1,2,3..., 1 = all ones, 2 = random.
  task automatic gen_vals(input int dmode, input int k, input int epb,
                          output logic [7:0] v0, output logic [7:0] v1);
    case (dmode)
      0: begin
        v0 = 8'(k * epb + 1);
        v1 = 8'(k * epb + 2);
      end
      1: begin
        v0 = 8'd1;
        v1 = 8'd1;
      end
      default: begin
        v0 = 8'($urandom_range(0, 255));
        v1 = 8'($urandom_range(0, 255));
      end
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_tready"}, 32'(tready_s[i]), 0);
      chk({tag, "_busy"},   32'(busy_s[i]), 0);
      chk({tag, "_done"},   32'(done_s[i]), 0);
      chk({tag, "_bc"},     bc_s[i], 0);
      chk({tag, "_cs"},     cs_s[i], 0);
      chk({tag, "_ee"},     32'(ee_s[i]), 0);
      chk({tag, "_em"},     32'(em_s[i]), 0);
    end
  endtask

  // Drives one frame and pushes the expected state after every beat that will be accepted.
  task automatic run_frame(input int inst, input int early_at, input bit no_last,
                           input int dmode, input bit gaps, input int stop_after,
                           input bit start_on_final, output int lows);
    int          total, epb, k, cyc;
    logic [7:0]  v0, v1;
    logic [31:0] sum;
    logic        ee, lst;
    exp_t        e;
    total = total_of(inst);
    epb   = (inst == 1) ? 2 : 1;
    @(negedge clk);
    start_s[inst] = 1'b1;
    @(negedge clk);
    start_s[inst] = 1'b0;
    chk("start_busy", 32'(busy_s[inst]), 1);
    chk("start_done", 32'(done_s[inst]), 0);
    chk("start_bc",   bc_s[inst], 0);
    chk("start_cs",   cs_s[inst], 0);
    chk("start_errs", {30'd0, ee_s[inst], em_s[inst]}, 0);
    k = 0; cyc = 0; lows = 0; sum = '0; ee = 1'b0;
    gen_vals(dmode, k, epb, v0, v1);
    while (k < total && !(stop_after != 0 && k >= stop_after) && cyc < LIMIT) begin
      if (!tready_s[inst]) lows++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        tvalid_s[inst] = 1'b0;
      end else begin
        lst = no_last ? 1'b0 : ((k + 1 == total) || (k + 1 == early_at));
        drive_beat(inst, 1'b1, lst, v0, v1);
        if (tready_s[inst]) begin
          sum = sum + 32'(v0) + ((epb == 2) ? 32'(v1) : 32'd0);
          if (lst && (k + 1 < total)) ee = 1'b1;
          e.inst = 2'(inst);
          e.bc   = 32'(k + 1);
          e.cs   = sum;
          e.ee   = ee;
          e.em   = (k + 1 == total) && !lst;
          e.fin  = (k + 1 == total);
          exp_q.push_back(e);
          k++;
          if (start_on_final && k == total) start_s[inst] = 1'b1;
          gen_vals(dmode, k, epb, v0, v1);
        end
      end
      @(negedge clk);
      cyc++;
    end
    tvalid_s[inst] = 1'b0;
    tlast_s[inst]  = 1'b0;
    start_s[inst]  = 1'b0;
    chk("frame_in_budget", 32'(cyc < LIMIT), 1);
  endtask

  // Record handshakes as the DUT sees them at the edge.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) acc_seen[i] = tvalid_s[i] && tready_s[i];
  end

  // After each accepted beat, compare the DUT's visible state with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (acc_seen[i]) begin
        chk("mon_queue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("mon_inst", 32'(e.inst), 32'(i));
          chk("mon_beat_count", bc_s[i], e.bc);
          chk("mon_checksum", cs_s[i], e.cs);
          chk("mon_err_early", 32'(ee_s[i]), 32'(e.ee));
          chk("mon_err_missing", 32'(em_s[i]), 32'(e.em));
          chk("mon_done", 32'(done_s[i]), 32'(e.fin));
          chk("mon_busy", 32'(busy_s[i]), 32'(!e.fin));
          if (e.fin) chk("mon_tready_after_last", 32'(tready_s[i]), 0);
        end
      end
    end
  end

  initial begin
    int lows;
    int early;
    int inst;
    bit nl;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i]  = 1'b0;
      tvalid_s[i] = 1'b0;
      tlast_s[i]  = 1'b0;
      acc_seen[i] = 1'b0;
    end
    td_a[0][0][0][0] = '0;
    td_b[0][0][0][0] = '0;
    td_b[0][0][0][1] = '0;
    td_c[0][0][0][0] = '0;
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    // Clean sequential frame, then early tlast, then missing tlast.
    run_frame(0, 0, 1'b0, 0, 1'b0, 0, 1'b0, lows);
    chk("a_clean_sum", cs_s[0], 36);
    run_frame(0, 3, 1'b0, 0, 1'b0, 0, 1'b0, lows);
    chk("a_early_flag", 32'(ee_s[0]), 1);
    run_frame(0, 0, 1'b1, 0, 1'b0, 0, 1'b0, lows);
    chk("a_missing_flag", 32'(em_s[0]), 1);

    // Two-wide stencil frame.
    run_frame(1, 0, 1'b0, 0, 1'b0, 0, 1'b0, lows);
    chk("b_beats", bc_s[1], 4);
    chk("b_sum", cs_s[1], 36);

    // Long frame with tvalid held and random stalls.
    run_frame(2, 0, 1'b0, 1, 1'b0, 0, 1'b0, lows);
    chk("c_stall_seen", 32'(lows > 0), 1);
    chk("c_beats", bc_s[2], 256);
    chk("c_sum", cs_s[2], 256);

    // start_in on the final-beat edge is ignored.
    run_frame(0, 0, 1'b0, 0, 1'b0, 0, 1'b1, lows);
    @(negedge clk);
    chk("final_start_done", 32'(done_s[0]), 1);
    chk("final_start_bc", bc_s[0], 8);

    // Reset mid-frame after three beats, then two clean frames.
    run_frame(0, 0, 1'b0, 0, 1'b0, 3, 1'b0, lows);
    chk("pre_reset_bc", bc_s[0], 3);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    run_frame(0, 0, 1'b0, 0, 1'b0, 0, 1'b0, lows);
    chk("post_reset_sum", cs_s[0], 36);
    run_frame(0, 0, 1'b0, 0, 1'b0, 0, 1'b0, lows);
    chk("restart_sum", cs_s[0], 36);
    chk("restart_done", 32'(done_s[0]), 1);

    // Randomized frames on the small configurations.
    for (int r = 0; r < 8; r++) begin
      inst  = $urandom_range(0, 1);
      early = $urandom_range(0, total_of(inst) - 1);
      nl    = ($urandom_range(0, 3) == 0);
      run_frame(inst, early, nl, 2, 1'b1, 0, 1'b0, lows);
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
